// File: rtl/packet_slot_queue.sv
`default_nettype none
// ============================================================================
// Module   : packet_slot_queue
// Purpose  : Slot-partitioned packet buffer controller with whole-packet drop
//            on overflow and a start/done handshake towards the consumer.
// Revision : 1.0 - initial release
// ============================================================================
module packet_slot_queue #(
   parameter int WORD_LEN   = 8,
   parameter int SLOT_LEN   = 914,
   parameter int NUM_SLOTS  = 8,
   parameter int DROP_CNT_W = 16,
   localparam int PART_LEN  = 2**$clog2(SLOT_LEN),
   localparam int SW        = $clog2(NUM_SLOTS),
   localparam int CW        = $clog2(PART_LEN),
   localparam int AW        = SW + CW
) (
   input  logic                  clk,
   input  logic                  rstn,
   input  logic                  inclk,
   input  logic [WORD_LEN-1:0]   in,
   input  logic                  in_last,
   input  logic                  wr_abort,
   output logic                  ram_we,
   output logic [AW-1:0]         ram_waddr,
   output logic [WORD_LEN-1:0]   ram_win,
   output logic                  rd_start,
   output logic [AW-1:0]         rd_base,
   output logic [AW-1:0]         rd_end,
   input  logic                  rd_done,
   output logic [SW:0]           count,
   output logic                  full,
   output logic                  empty,
   output logic [DROP_CNT_W-1:0] drops
);

   localparam logic       c_W_ACCEPT = 1'b0;
   localparam logic       c_W_DROP   = 1'b1;
   localparam logic [1:0] c_R_IDLE   = 2'd0;
   localparam logic [1:0] c_R_START  = 2'd1;
   localparam logic [1:0] c_R_ACTIVE = 2'd2;

   logic                  r_wstate;
   logic [1:0]            r_rstate;
   logic [1:0]            w_rnext;
   logic [SW-1:0]         r_head;
   logic [SW-1:0]         r_tail;
   logic [CW-1:0]         r_wcnt;
   logic [SW:0]           r_count;
   logic [DROP_CNT_W-1:0] r_drops;
   logic [CW:0]           r_len [NUM_SLOTS];
   logic [AW-1:0]         r_rd_base;
   logic [AW-1:0]         r_rd_end;

   logic          w_full;
   logic          w_first;
   logic          w_accepting;
   logic          w_reject;
   logic          w_we;
   logic          w_commit;
   logic          w_pop;
   logic [AW-1:0] w_base;

   assign w_full      = (r_count == (SW+1)'(NUM_SLOTS));
   assign w_first     = (r_wcnt == '0);
   assign w_accepting = inclk && (r_wstate == c_W_ACCEPT) && !wr_abort;
   // A packet is refused only at its first word; later words always have room.
   assign w_reject    = w_accepting && w_first && w_full;
   assign w_we        = w_accepting && !(w_first && w_full);
   assign w_commit    = w_we && (in_last || (r_wcnt == CW'(SLOT_LEN-1)));
   assign w_pop       = (r_rstate == c_R_ACTIVE) && rd_done;
   assign w_base      = {r_head, {CW{1'b0}}};

   assign ram_we    = w_we;
   assign ram_waddr = {r_tail, r_wcnt};
   assign ram_win   = in;
   assign count     = r_count;
   assign full      = w_full;
   assign empty     = (r_count == '0);
   assign drops     = r_drops;
   assign rd_base   = r_rd_base;
   assign rd_end    = r_rd_end;

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         r_wstate <= c_W_ACCEPT;
         r_wcnt   <= '0;
         r_tail   <= '0;
      end else if (wr_abort) begin
         r_wcnt   <= '0;
         r_wstate <= c_W_ACCEPT;
      end else if (inclk) begin
         if (r_wstate == c_W_DROP) begin
            if (in_last) r_wstate <= c_W_ACCEPT;
         end else if (w_reject) begin
            if (!in_last) r_wstate <= c_W_DROP;
         end else if (w_commit) begin
            r_wcnt <= '0;
            r_tail <= r_tail + SW'(1);
         end else begin
            r_wcnt <= r_wcnt + CW'(1);
         end
      end
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn)
         r_drops <= '0;
      else if (w_reject && (r_drops != '1))
         r_drops <= r_drops + DROP_CNT_W'(1);
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         r_count <= '0;
      end else begin
         case ({w_commit, w_pop})
            2'b10:   r_count <= r_count + (SW+1)'(1);
            2'b01:   r_count <= r_count - (SW+1)'(1);
            default: r_count <= r_count;
         endcase
      end
   end

   for (genvar i = 0; i < NUM_SLOTS; i++) begin : g_len
      always_ff @(posedge clk or negedge rstn) begin
         if (!rstn)
            r_len[i] <= '0;
         else if (w_commit && (r_tail == SW'(i)))
            r_len[i] <= {1'b0, r_wcnt} + (CW+1)'(1);
      end
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) r_rstate <= c_R_IDLE;
      else       r_rstate <= w_rnext;
   end

   always_comb begin
      w_rnext = r_rstate;
      case (r_rstate)
         c_R_IDLE:   if (r_count != '0) w_rnext = c_R_START;
         c_R_START:  w_rnext = c_R_ACTIVE;
         c_R_ACTIVE: if (rd_done) w_rnext = c_R_IDLE;
         default:    w_rnext = c_R_IDLE;
      endcase
   end

   always_comb begin
      rd_start = 1'b0;
      if (r_rstate == c_R_START) rd_start = 1'b1;
   end

   // Read window is latched once per packet and held until the consumer is done.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         r_rd_base <= '0;
         r_rd_end  <= '0;
         r_head    <= '0;
      end else begin
         if ((r_rstate == c_R_IDLE) && (w_rnext == c_R_START)) begin
            r_rd_base <= w_base;
            r_rd_end  <= w_base + AW'(r_len[r_head]);
         end
         if (w_pop) r_head <= r_head + SW'(1);
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_packet_slot_queue.sv
`default_nettype none
// ============================================================================
// Module   : tb_packet_slot_queue
// Purpose  : Self-checking bench: vector table, directed corner sequences and
//            random traffic against a queue-based reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_packet_slot_queue;

   localparam int WL   = 8;
   localparam int SL   = 4;
   localparam int NS   = 4;
   localparam int DW   = 4;
   localparam int PART = 4;
   localparam int AW   = 4;
   localparam int DMAX = (1 << DW) - 1;

   logic          clk = 1'b0;
   logic          rstn = 1'b0;
   logic          inclk = 1'b0;
   logic [WL-1:0] din = '0;
   logic          in_last = 1'b0;
   logic          wr_abort = 1'b0;
   logic          rd_done = 1'b0;
   logic          ram_we;
   logic [AW-1:0] ram_waddr;
   logic [WL-1:0] ram_win;
   logic          rd_start;
   logic [AW-1:0] rd_base;
   logic [AW-1:0] rd_end;
   logic [2:0]    count;
   logic          full;
   logic          empty;
   logic [DW-1:0] drops;

   packet_slot_queue #(
      .WORD_LEN(WL), .SLOT_LEN(SL), .NUM_SLOTS(NS), .DROP_CNT_W(DW)
   ) dut (
      .clk(clk), .rstn(rstn), .inclk(inclk), .in(din), .in_last(in_last),
      .wr_abort(wr_abort), .ram_we(ram_we), .ram_waddr(ram_waddr),
      .ram_win(ram_win), .rd_start(rd_start), .rd_base(rd_base),
      .rd_end(rd_end), .rd_done(rd_done), .count(count), .full(full),
      .empty(empty), .drops(drops)
   );

   always #5 clk = ~clk;

   int total = 0;
   int bad   = 0;

   // Reference model: committed packets as a queue of (slot, length).
   int q_slot[$];
   int q_len[$];
   int m_tail, m_cur, m_drops, m_stage, m_base, m_end;
   bit m_dropping;

   task automatic check(input string name, input int act, input int exp);
      total++;
      if (act != exp) begin
         bad++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   task automatic model_reset();
      q_slot.delete();
      q_len.delete();
      m_tail = 0; m_cur = 0; m_drops = 0; m_stage = 0;
      m_base = 0; m_end = 0; m_dropping = 0;
   endtask

   task automatic step(input bit ic, input logic [WL-1:0] d, input bit last,
                       input bit ab, input bit done);
      int  n;
      bit  mfull;
      bit  exp_we;
      @(negedge clk);
      inclk = ic; din = d; in_last = last; wr_abort = ab; rd_done = done;
      #1;
      n      = q_slot.size();
      mfull  = (n == NS);
      exp_we = ic && !m_dropping && !ab && !(m_cur == 0 && mfull);
      check("we", ram_we, exp_we);
      if (exp_we) begin
         check("waddr", ram_waddr, m_tail * PART + m_cur);
         check("win", ram_win, d);
      end
      check("count", count, n);
      check("full", full, mfull);
      check("empty", empty, n == 0);
      check("drops", drops, m_drops);
      check("rd_start", rd_start, m_stage == 1);
      check("rd_base", rd_base, m_base);
      check("rd_end", rd_end, m_end);
      // advance the model across the coming edge
      if (m_stage == 0 && n != 0) begin
         m_stage = 1;
         m_base  = q_slot[0] * PART;
         m_end   = (m_base + q_len[0]) % (NS * PART);
      end else if (m_stage == 1) begin
         m_stage = 2;
      end else if (m_stage == 2 && done) begin
         m_stage = 0;
         void'(q_slot.pop_front());
         void'(q_len.pop_front());
      end
      if (ab) begin
         m_cur = 0; m_dropping = 0;
      end else if (ic) begin
         if (m_dropping) begin
            if (last) m_dropping = 0;
         end else if (m_cur == 0 && mfull) begin
            if (m_drops < DMAX) m_drops++;
            m_dropping = !last;
         end else if (last || m_cur == SL - 1) begin
            q_slot.push_back(m_tail);
            q_len.push_back(m_cur + 1);
            m_tail = (m_tail + 1) % NS;
            m_cur  = 0;
         end else begin
            m_cur++;
         end
      end
   endtask

   task automatic idle(input bit done);
      step(1'b0, '0, 1'b0, 1'b0, done);
   endtask

   task automatic do_reset();
      @(negedge clk);
      rstn = 1'b0; inclk = 0; in_last = 0; wr_abort = 0; rd_done = 0;
      model_reset();
      repeat (2) @(posedge clk);
      #1;
      check("rst_count", count, 0);
      check("rst_empty", empty, 1);
      check("rst_full", full, 0);
      check("rst_drops", drops, 0);
      check("rst_start", rd_start, 0);
      check("rst_base", rd_base, 0);
      check("rst_end", rd_end, 0);
      check("rst_we", ram_we, 0);
      @(negedge clk);
      rstn = 1'b1;
   endtask

   typedef struct {
      bit         ic;
      logic [7:0] d;
      bit         last;
      bit         done;
      bit         we;
      int         waddr;
      int         cnt;
      bit         start;
      int         base;
      int         rend;
   } vec_t;

   vec_t tbl[11];

   initial begin
      int found, wend;

      tbl[0]  = '{1, 8'hA1, 0, 0, 1, 0, 0, 0, 0, 0};
      tbl[1]  = '{1, 8'hB2, 0, 0, 1, 1, 0, 0, 0, 0};
      tbl[2]  = '{1, 8'hC3, 1, 0, 1, 2, 0, 0, 0, 0};
      tbl[3]  = '{0, 8'h00, 0, 0, 0, 0, 1, 0, 0, 0};
      tbl[4]  = '{0, 8'h00, 0, 0, 0, 0, 1, 1, 0, 3};
      tbl[5]  = '{0, 8'h00, 0, 1, 0, 0, 1, 0, 0, 3};
      tbl[6]  = '{1, 8'hD4, 1, 0, 1, 4, 0, 0, 0, 3};
      tbl[7]  = '{0, 8'h00, 0, 0, 0, 0, 1, 0, 0, 3};
      tbl[8]  = '{0, 8'h00, 0, 0, 0, 0, 1, 1, 4, 5};
      tbl[9]  = '{0, 8'h00, 0, 1, 0, 0, 1, 0, 4, 5};
      tbl[10] = '{0, 8'h00, 0, 0, 0, 0, 0, 0, 4, 5};

      do_reset();
      for (int i = 0; i < 11; i++) begin
         step(tbl[i].ic, tbl[i].d, tbl[i].last, 1'b0, tbl[i].done);
         check("tbl_we", ram_we, tbl[i].we);
         if (tbl[i].we) check("tbl_waddr", ram_waddr, tbl[i].waddr);
         check("tbl_count", count, tbl[i].cnt);
         check("tbl_start", rd_start, tbl[i].start);
         check("tbl_base", rd_base, tbl[i].base);
         check("tbl_end", rd_end, tbl[i].rend);
      end

      // auto-commit at maximum length, following words start a new packet
      do_reset();
      for (int i = 0; i < 6; i++) begin
         step(1'b1, 8'(i), 1'b0, 1'b0, 1'b0);
         check("auto_waddr", ram_waddr, i);
         if (i == 4) check("auto_count", count, 1);
         if (i == 5) begin
            check("auto_start", rd_start, 1);
            check("auto_end", rd_end, 4);
         end
      end
      step(1'b0, '0, 1'b0, 1'b1, 1'b0);

      // overflow drop while full
      do_reset();
      for (int i = 0; i < 4; i++) step(1'b1, 8'(8'h10 + i), 1'b1, 1'b0, 1'b0);
      step(1'b1, 8'h55, 1'b1, 1'b0, 1'b0);
      check("full_flag", full, 1);
      check("full_no_we", ram_we, 0);
      idle(1'b0);
      check("full_drops", drops, 1);
      check("full_count", count, 4);

      // multi-word drop, drop coincident with pop, then slot reuse
      do_reset();
      for (int i = 0; i < 4; i++) step(1'b1, 8'(8'h20 + i), 1'b1, 1'b0, 1'b0);
      step(1'b1, 8'h30, 1'b0, 1'b0, 1'b0);
      check("drop_w1_we", ram_we, 0);
      step(1'b1, 8'h31, 1'b1, 1'b0, 1'b0);
      check("drop_w2_we", ram_we, 0);
      idle(1'b0);
      check("drop_pkt_drops", drops, 1);
      step(1'b1, 8'h40, 1'b1, 1'b0, 1'b1);
      check("pop_same_cycle_we", ram_we, 0);
      idle(1'b0);
      check("pop_same_drops", drops, 2);
      check("pop_same_count", count, 3);
      step(1'b1, 8'h41, 1'b1, 1'b0, 1'b0);
      check("reuse_we", ram_we, 1);
      check("reuse_waddr", ram_waddr, 0);
      idle(1'b0);
      check("reuse_count", count, 4);
      for (int i = 0; i < 16; i++) step(1'b1, 8'h77, 1'b1, 1'b0, 1'b0);
      idle(1'b0);
      check("drops_saturate", drops, DMAX);

      // abort coincident with a word
      do_reset();
      step(1'b1, 8'h61, 1'b0, 1'b0, 1'b0);
      step(1'b1, 8'h62, 1'b0, 1'b0, 1'b0);
      step(1'b1, 8'h63, 1'b0, 1'b1, 1'b0);
      check("abort_we", ram_we, 0);
      step(1'b1, 8'h64, 1'b1, 1'b0, 1'b0);
      check("abort_next_we", ram_we, 1);
      check("abort_next_waddr", ram_waddr, 0);
      idle(1'b0);
      check("abort_count", count, 1);
      check("abort_drops", drops, 0);

      // rd_end wraps to 0 for a full-length packet in the last slot
      do_reset();
      for (int i = 0; i < 3; i++) step(1'b1, 8'h70, 1'b1, 1'b0, 1'b1);
      for (int i = 0; i < 4; i++) step(1'b1, 8'h71, 1'b0, 1'b0, 1'b1);
      found = 0; wend = -1;
      for (int i = 0; i < 40 && found == 0; i++) begin
         idle(1'b1);
         if (rd_start && rd_base == 12) begin found = 1; wend = rd_end; end
      end
      check("wrap_found", found, 1);
      check("wrap_end", wend, 0);

      // asynchronous reset while a packet is being read
      do_reset();
      step(1'b1, 8'h81, 1'b1, 1'b0, 1'b1);
      for (int i = 0; i < 4; i++) idle(1'b1);
      step(1'b1, 8'h82, 1'b1, 1'b0, 1'b0);
      step(1'b1, 8'h83, 1'b1, 1'b0, 1'b0);
      for (int i = 0; i < 3; i++) idle(1'b0);
      check("pre_rst_count", count, 2);
      check("pre_rst_base", rd_base, 4);
      #2;
      rstn = 1'b0;
      #1;
      check("arst_count", count, 0);
      check("arst_empty", empty, 1);
      check("arst_start", rd_start, 0);
      check("arst_base", rd_base, 0);
      model_reset();
      @(posedge clk);
      @(negedge clk);
      rstn = 1'b1;
      for (int i = 0; i < 5; i++) begin
         idle(1'b0);
         check("post_rst_start", rd_start, 0);
      end

      // random traffic against the model
      do_reset();
      for (int i = 0; i < 2500; i++) begin
         step($urandom_range(0, 99) < 70, 8'($urandom), $urandom_range(0, 99) < 30,
              $urandom_range(0, 99) < 3, $urandom_range(0, 99) < 35);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/packet_slot_queue.md
Name: packet_slot_queue

Overview:
- Parametrised packet-buffer queue controller between a byte producer (UART RX / fgp_rx / AES encrypt path) and a packet consumer (stream_from_memory feeding eth_tx).
- Partitions the packet buffer RAM into NUM_SLOTS fixed-size slots and stores variable-length packets with a per-slot length.
- Drops whole packets on overflow and counts the drops.
- Drives a start/done handshake to the consumer and supplies the read window for each packet.

Parameters:
- WORD_LEN, 8, data word width.
- SLOT_LEN, 914, maximum words per packet; slot stride PART_LEN = 2**clog2(SLOT_LEN).
- NUM_SLOTS, 8, slot count; must be a power of 2, at least 2.
- DROP_CNT_W, 16, width of the saturating drop counter.
- Derived: SW = clog2(NUM_SLOTS), CW = clog2(PART_LEN), AW = SW+CW.

Ports:
- clk  in  1  single system clock; all logic on posedge.
- rstn  in  1  asynchronous, active-low reset.
- inclk  in  1  input word valid strobe.
- in  in  WORD_LEN  input word.
- in_last  in  1  qualifies inclk: this word ends the packet.
- wr_abort  in  1  discard the partially written packet.
- ram_we  out  1  RAM write enable.
- ram_waddr  out  AW  RAM write address.
- ram_win  out  WORD_LEN  RAM write data.
- rd_start  out  1  one-cycle pulse: packet available for the consumer.
- rd_base  out  AW  first address of the packet, {head, CW zeros}.
- rd_end  out  AW  rd_base + stored length (exclusive end).
- rd_done  in  1  consumer finished with the current packet.
- count  out  SW+1  committed packets queued (0..NUM_SLOTS).
- full  out  1  count == NUM_SLOTS.
- empty  out  1  count == 0.
- drops  out  DROP_CNT_W  dropped-packet count, saturating.

Behaviour:

Reset (rstn low, asynchronous):
- head, tail, wcnt, count, drops and all length registers = 0.
- Write state = ACCEPT; read state = IDLE.
- rd_start = 0, rd_base = 0, rd_end = 0.

Write side:
- Write path is combinational. ram_we = inclk && write state ACCEPT && !wr_abort && !(wcnt==0 && full). ram_waddr = {tail, wcnt}. ram_win = in.
- First word of a packet (wcnt == 0) while full: no write. Enter DROP, or stay in ACCEPT if in_last is also set. Either way, drops increments, saturating at all-ones.
- DROP state: all words are ignored until an inclk with in_last, then return to ACCEPT. Only one drop is counted per packet.
- Commit happens on a written word with in_last, or on wcnt == SLOT_LEN-1 (auto-commit at maximum length). On commit: len[tail] <= wcnt+1, tail <= tail+1 (wraps mod NUM_SLOTS), wcnt <= 0, count increments.
- Words after an auto-commit without in_last start a new packet.
- Otherwise each written word increments wcnt.
- wr_abort: wcnt <= 0 and write state <= ACCEPT; no commit, no drop count. wr_abort has priority over a coincident inclk.
- All NUM_SLOTS slots are usable; no slot is sacrificed for full detection.

Read side FSM:
- IDLE: if count != 0, go to START. rd_base and rd_end are registered from head and len[head] on this transition.
- START: rd_start = 1 for exactly this cycle; go to ACTIVE.
- ACTIVE: rd_base and rd_end are held stable. On rd_done: head <= head+1, count decrements, go to IDLE.
- rd_done outside ACTIVE is ignored.

Latency:
- Commit edge E: count and empty update at E.
- The IDLE->START transition occurs at E+1, so rd_start is high in the cycle after E+1.
- After rd_done, the next rd_start comes at least 2 cycles later, giving the consumer a one-cycle gap like eth_tx_start.

Simultaneous events:
- Commit and pop on the same edge: count is unchanged, and tail and head both advance.
- Committing into the last free slot while a pop occurs is legal. Full is evaluated from the registered count before the edge.
- A drop decision uses the registered full; a slot freed on the same edge does not rescue that packet.

Width rules:
- rd_end = {head, CW zeros} + len, computed in AW bits.
- With the last slot and len == PART_LEN, rd_end wraps to 0. The consumer compares for equality, so this is legal.

Test Plan:
- SLOT_LEN=4, NUM_SLOTS=4, 3-word packet A,B,C with in_last on C -> writes at addresses 0,1,2; count=1; rd_start pulses 2 cycles after commit with rd_base=0, rd_end=3; rd_done -> count=0, head=1.
- 6 words with no in_last -> first 4 words auto-commit to slot 0 with len 4; words 5 and 6 go to addresses 4 and 5; count=1.
- rd_done held low; 5 one-word packets -> slots 0..3 filled, full=1; 5th packet produces no ram_we and drops=1; count stays 4.
- 2-word packet in DROP, then a 1-word packet after rd_done frees a slot -> first packet not written and drops=1; second packet written to slot 0 with len 1; inclk on the same cycle as rd_done still drops.
- 2 words written, then wr_abort coincident with a 3rd inclk -> no write that cycle; next packet starts at offset 0 of the same slot; count and drops unchanged.
- rstn pulled low while the read FSM is in ACTIVE with count=2 -> immediately count=0, empty=1, rd_start=0, rd_base=0; no rd_start after rstn is released.
